// File: rtl/screen_pkg.sv
// rtl/screen_pkg.sv - shared constants and clear-FSM state type for the screen write arbiter
package screen_pkg;

    localparam logic [15:0] BUF_START = 16'h0400;
    localparam int          BUF_WORDS = 1200;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, power-of-2 depth, push and pop allowed together when full
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head_o  = mem_q[rd_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + (PW+1)'(push_i);
            rd_q <= rd_q + (PW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q[PW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/screen_wr_arbiter.sv
// rtl/screen_wr_arbiter.sv - owns the screen-buffer write port: CPU > clear > keyboard FIFO
// Optional round-robin relief for starved requesters: SCRN_ARB_FAIR_EN.
module screen_wr_arbiter #(
    parameter int            AW         = 16,
    parameter int            DW         = 16,
    parameter int            FIFO_DEPTH = 4,
    parameter logic [AW-1:0] BUF_START  = screen_pkg::BUF_START,
    parameter int            BUF_WORDS  = screen_pkg::BUF_WORDS
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CPU_MW,
    input  logic [AW-1:0] CPU_WADDR,
    input  logic [DW-1:0] CPU_WDATA,
    input  logic          KB_MW,
    input  logic [AW-1:0] KB_WADDR,
    input  logic [DW-1:0] KB_WDATA,
    input  logic          CLR_REQ,
    output logic          CLR_BUSY,
    output logic          KB_OVF,
    output logic          CPU_WAIT,
    output logic [AW-1:0] WADDR_SCREEN,
    output logic [DW-1:0] DATA_IN_SCREEN,
    output logic          MW_SCREEN_ON
);

    import screen_pkg::*;

    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AW+DW-1:0]    fifo_head;
    clr_state_e          clr_state_q, clr_state_d;
    logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
    logic                clr_busy, clr_last, other_pend, cpu_block;
    logic                grant_cpu, grant_clr, grant_fifo;
    logic                mw_q, ovf_q;
    logic [AW-1:0]       waddr_q;
    logic [DW-1:0]       wdata_q;

    sync_fifo #(
        .W     (AW + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_kb_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (fifo_push),
        .din_i   ({KB_WADDR, KB_WDATA}),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign clr_busy   = (clr_state_q == RUN);
    assign clr_last   = (clr_cnt_q == AW'(BUF_WORDS - 1));
    assign other_pend = clr_busy || !fifo_empty;

`ifdef SCRN_ARB_FAIR_EN
    // Counts back-to-back CPU wins while someone else is waiting; at 7 the next slot is theirs.
    logic [2:0] fair_q, fair_d;

    assign cpu_block = (fair_q == 3'd7) && other_pend;

    always_comb begin
        fair_d = 3'd0;
        if (grant_cpu && other_pend) begin
            fair_d = fair_q + 3'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fair_q <= 3'd0;
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    assign cpu_block = 1'b0;
`endif

    assign CPU_WAIT   = cpu_block;
    assign grant_cpu  = CPU_MW && !cpu_block;
    assign grant_clr  = !grant_cpu && clr_busy;
    // Keyboard writes are held back for the whole clear so they land on a blank screen.
    assign grant_fifo = !grant_cpu && !clr_busy && !fifo_empty;
    assign fifo_pop   = grant_fifo;
    assign fifo_push  = KB_MW && (!fifo_full || fifo_pop);

    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        case (clr_state_q)
            IDLE: begin
                if (CLR_REQ) begin
                    clr_state_d = RUN;
                    clr_cnt_d   = '0;
                end
            end
            RUN: begin
                if (grant_clr) begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                    if (clr_last) begin
                        clr_state_d = IDLE;
                    end
                end
            end
            default: clr_state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clr_state_q <= IDLE;
            clr_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            mw_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
            ovf_q       <= ovf_q | (KB_MW && fifo_full && !fifo_pop);
            mw_q        <= grant_cpu || grant_clr || grant_fifo;
            if (grant_cpu) begin
                waddr_q <= CPU_WADDR;
                wdata_q <= CPU_WDATA;
            end else if (grant_clr) begin
                waddr_q <= BUF_START + clr_cnt_q;
                wdata_q <= '0;
            end else if (grant_fifo) begin
                {waddr_q, wdata_q} <= fifo_head;
            end
        end
    end

    assign CLR_BUSY       = clr_busy;
    assign KB_OVF         = ovf_q;
    assign WADDR_SCREEN   = waddr_q;
    assign DATA_IN_SCREEN = wdata_q;
    assign MW_SCREEN_ON   = mw_q;

endmodule
